// File: rtl/sn_cfg_pkg.sv
// Shared types and width helpers for the runtime synapse-table loader.
package sn_cfg_pkg;

  typedef enum logic [7:0] {
    OP_WRITE_ROW = 8'h01,
    OP_SET_ROWS  = 8'h02,
    OP_COMMIT    = 8'h03,
    OP_CLEAR     = 8'h04
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_NEUR      = 3'd1,
    ST_ROW       = 3'd2,
    ST_DATA      = 3'd3,
    ST_CNT       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  // Entry is {presynaptic index, signed weight}.
  function automatic int entry_width(input int idx_bw, input int w_bw);
    return idx_bw + w_bw;
  endfunction

  function automatic int entry_bytes(input int entry_bw);
    return (entry_bw + 7) / 8;
  endfunction

endpackage

// File: rtl/sn_cfg_pkt_parser.sv
// Byte-stream packet parser: decodes opcodes, validates fields and emits
// single-cycle write strobes for the shadow bank and the commit copy.
module sn_cfg_pkt_parser
  import sn_cfg_pkg::*;
#(
  parameter int P_NUM_NEURONS = 21,
  parameter int P_NUM_INPUTS  = 9,
  parameter int P_MAX_ROWS    = 4,
  parameter int P_ENTRY_BW    = 14,
  localparam int NIDX_BW = $clog2(P_NUM_NEURONS - P_NUM_INPUTS + 1),
  localparam int ROW_BW  = (P_MAX_ROWS > 1) ? $clog2(P_MAX_ROWS) : 1,
  localparam int CNT_BW  = $clog2(P_MAX_ROWS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  net_idle,
  output logic                  row_wr,
  output logic                  cnt_wr,
  output logic                  commit,
  output logic                  clear,
  output logic [NIDX_BW-1:0]    neur_idx,
  output logic [ROW_BW-1:0]     row,
  output logic [CNT_BW-1:0]     cnt,
  output logic [P_ENTRY_BW-1:0] entry,
  output logic                  done,
  output logic                  err
);

  localparam int EB      = entry_bytes(P_ENTRY_BW);
  localparam int BCNT_BW = (EB > 1) ? $clog2(EB) : 1;
  localparam int DATA_BW = EB * 8;

  localparam logic [7:0]         NEUR_LO   = 8'(P_NUM_INPUTS);
  localparam logic [7:0]         NEUR_HI   = 8'(P_NUM_NEURONS);
  localparam logic [7:0]         ROWS_MAX  = 8'(P_MAX_ROWS);
  localparam logic [BCNT_BW-1:0] BCNT_LAST = BCNT_BW'(EB - 1);

  state_e               state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic                 bad_q, bad_d;
  logic [7:0]           neur_q, neur_d;
  logic [ROW_BW-1:0]    row_q, row_d;
  logic [BCNT_BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DATA_BW-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_BW-1:0]   asm_v;
  logic                 accept;
  logic                 neur_ok;

  assign in_ready = (state_q != ST_WAIT_IDLE);
  assign accept   = in_valid & in_ready;
  assign neur_ok  = (in_data > NEUR_LO) && (in_data <= NEUR_HI);

  assign neur_idx = NIDX_BW'(neur_q - NEUR_LO);
  assign row      = row_q;
  assign cnt      = in_data[CNT_BW-1:0];
  assign entry    = asm_v[P_ENTRY_BW-1:0];
  assign done     = done_q;
  assign err      = err_q;

  // Little-endian assembly; the final byte is merged combinationally so the
  // shadow write lands on the edge that accepts it.
  always_comb begin
    asm_v = data_q;
    for (int i = 0; i < EB; i++) begin
      if (byte_cnt_q == BCNT_BW'(i)) asm_v[i*8 +: 8] = in_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    bad_d      = bad_q;
    neur_d     = neur_q;
    row_d      = row_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    row_wr     = 1'b0;
    cnt_wr     = 1'b0;
    commit     = 1'b0;
    clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bad_d      = 1'b0;
          byte_cnt_d = '0;
          data_d     = '0;
          case (in_data)
            OP_WRITE_ROW: begin
              is_write_d = 1'b1;
              state_d    = ST_NEUR;
            end
            OP_SET_ROWS: begin
              is_write_d = 1'b0;
              state_d    = ST_NEUR;
            end
            OP_COMMIT: state_d = ST_WAIT_IDLE;
            OP_CLEAR: begin
              clear  = 1'b1;
              done_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_NEUR: begin
        if (accept) begin
          neur_d  = in_data;
          bad_d   = bad_q | ~neur_ok;
          state_d = is_write_q ? ST_ROW : ST_CNT;
        end
      end

      ST_ROW: begin
        if (accept) begin
          row_d   = in_data[ROW_BW-1:0];
          bad_d   = bad_q | (in_data >= ROWS_MAX);
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (accept) begin
          data_d     = asm_v;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BCNT_LAST) begin
            state_d = ST_IDLE;
            if (bad_q) begin
              err_d = 1'b1;
            end else begin
              row_wr = 1'b1;
              done_d = 1'b1;
            end
          end
        end
      end

      ST_CNT: begin
        if (accept) begin
          state_d = ST_IDLE;
          if (bad_q || (in_data > ROWS_MAX)) begin
            err_d = 1'b1;
          end else begin
            cnt_wr = 1'b1;
            done_d = 1'b1;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // No timeout here: a stuck network is the protocol watchdog's problem.
        if (net_idle) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      bad_q      <= 1'b0;
      neur_q     <= '0;
      row_q      <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      bad_q      <= bad_d;
      neur_q     <= neur_d;
      row_q      <= row_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: rtl/sn_cfg_table_loader.sv
// Runtime synapse-table loader: shadow bank written by the parser, active bank
// updated atomically on commit and driven to the network.
module sn_cfg_table_loader
  import sn_cfg_pkg::*;
#(
  parameter int P_NUM_NEURONS        = 21,
  parameter int P_NUM_INPUTS         = 9,
  parameter int P_NUM_OUTPUTS        = 3,
  parameter int P_TABLE_MAX_NUM_ROWS = 4,
  parameter int P_TABLE_WEIGHT_BW    = 9,
  parameter int P_TABLE_IDX_BW       = $clog2(P_NUM_NEURONS - P_NUM_OUTPUTS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [7:0] in_data,
  output logic in_ready,
  input  logic net_idle,
  output logic [P_NUM_NEURONS-P_NUM_INPUTS:1][P_TABLE_MAX_NUM_ROWS-1:0]
               [P_TABLE_IDX_BW+P_TABLE_WEIGHT_BW-1:0] cfg_table_contents,
  output logic [P_NUM_NEURONS-P_NUM_INPUTS:1]
               [$clog2(P_TABLE_MAX_NUM_ROWS+1)-1:0] cfg_num_rows,
  output logic cfg_update,
  output logic done,
  output logic err
);

  localparam int NC      = P_NUM_NEURONS - P_NUM_INPUTS;
  localparam int R       = P_TABLE_MAX_NUM_ROWS;
  localparam int E       = entry_width(P_TABLE_IDX_BW, P_TABLE_WEIGHT_BW);
  localparam int NIDX_BW = $clog2(NC + 1);
  localparam int ROW_BW  = (R > 1) ? $clog2(R) : 1;
  localparam int RCNT_BW = $clog2(R + 1);

  typedef logic [NC:1][R-1:0][E-1:0] tab_t;
  typedef logic [NC:1][RCNT_BW-1:0]  rows_t;

  tab_t  sh_tab_q, sh_tab_d;
  rows_t sh_rows_q, sh_rows_d;
  tab_t  act_tab_q, act_tab_d;
  rows_t act_rows_q, act_rows_d;
  logic  cfg_update_q, cfg_update_d;

  logic               row_wr;
  logic               cnt_wr;
  logic               commit;
  logic               clear;
  logic [NIDX_BW-1:0] neur_idx;
  logic [ROW_BW-1:0]  row;
  logic [RCNT_BW-1:0] cnt;
  logic [E-1:0]       entry;

  sn_cfg_pkt_parser #(
    .P_NUM_NEURONS (P_NUM_NEURONS),
    .P_NUM_INPUTS  (P_NUM_INPUTS),
    .P_MAX_ROWS    (R),
    .P_ENTRY_BW    (E)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .net_idle (net_idle),
    .row_wr   (row_wr),
    .cnt_wr   (cnt_wr),
    .commit   (commit),
    .clear    (clear),
    .neur_idx (neur_idx),
    .row      (row),
    .cnt      (cnt),
    .entry    (entry),
    .done     (done),
    .err      (err)
  );

  // Commit reads the registered shadow, so contents and counts move together.
  always_comb begin
    sh_tab_d     = sh_tab_q;
    sh_rows_d    = sh_rows_q;
    act_tab_d    = act_tab_q;
    act_rows_d   = act_rows_q;
    cfg_update_d = 1'b0;
    if (clear) begin
      sh_tab_d  = '0;
      sh_rows_d = '0;
    end
    if (row_wr) sh_tab_d[neur_idx][row] = entry;
    if (cnt_wr) sh_rows_d[neur_idx] = cnt;
    if (commit) begin
      act_tab_d    = sh_tab_q;
      act_rows_d   = sh_rows_q;
      cfg_update_d = 1'b1;
    end
  end

  // NOTE: both banks are flop arrays, so they can and must be cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tab_q     <= '0;
      sh_rows_q    <= '0;
      act_tab_q    <= '0;
      act_rows_q   <= '0;
      cfg_update_q <= 1'b0;
    end else begin
      sh_tab_q     <= sh_tab_d;
      sh_rows_q    <= sh_rows_d;
      act_tab_q    <= act_tab_d;
      act_rows_q   <= act_rows_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign cfg_table_contents = act_tab_q;
  assign cfg_num_rows       = act_rows_q;
  assign cfg_update         = cfg_update_q;

endmodule

// File: tb/tb_sn_cfg_table_loader.sv
// Self-checking bench: directed vectors, corner sequences and random packets
// against a packet-level reference model of the shadow/active banks.
module tb_sn_cfg_table_loader;
  import sn_cfg_pkg::*;

  localparam int N   = 21;
  localparam int I   = 9;
  localparam int O   = 3;
  localparam int R   = 4;
  localparam int W   = 9;
  localparam int IDX = $clog2(N - O + 1);
  localparam int E   = IDX + W;
  localparam int NC  = N - I;
  localparam int RCW = $clog2(R + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic net_idle = 1'b1;
  logic in_ready;
  logic [NC:1][R-1:0][E-1:0] cfg_table_contents;
  logic [NC:1][RCW-1:0] cfg_num_rows;
  logic cfg_update, done, err;

  sn_cfg_table_loader #(
    .P_NUM_NEURONS(N), .P_NUM_INPUTS(I), .P_NUM_OUTPUTS(O),
    .P_TABLE_MAX_NUM_ROWS(R), .P_TABLE_WEIGHT_BW(W), .P_TABLE_IDX_BW(IDX)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .net_idle(net_idle),
    .cfg_table_contents(cfg_table_contents), .cfg_num_rows(cfg_num_rows),
    .cfg_update(cfg_update), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0, err_cnt = 0, upd_cnt = 0;
  int exp_done = 0, exp_err = 0, exp_upd = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (cfg_update === 1'b1) upd_cnt++;
  end

  // Reference model: neuron n lives at index n-I.
  int sh_tab [1:NC][0:R-1];
  int sh_rows [1:NC];
  int act_tab [1:NC][0:R-1];
  int act_rows [1:NC];

  typedef struct packed {
    logic [39:0] pkt;     // byte k at bits [8k+7:8k]
    logic        exp_ok;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int k = 1; k <= NC; k++) begin
      sh_rows[k] = 0;
      act_rows[k] = 0;
      for (int r = 0; r < R; r++) begin
        sh_tab[k][r] = 0;
        act_tab[k][r] = 0;
      end
    end
  endtask

  function automatic int pkt_len(input logic [7:0] op);
    if (op == 8'h01) return 5;
    if (op == 8'h02) return 3;
    return 1;
  endfunction

  task automatic model_packet(input logic [39:0] p, output bit ok);
    int op, n, r, val;
    op = int'(p[7:0]);
    n = int'(p[15:8]);
    r = int'(p[23:16]);
    val = int'(p[39:24]) & ((1 << E) - 1);
    ok = 1'b0;
    case (op)
      1: if (n > I && n <= N && r < R) begin ok = 1'b1; sh_tab[n-I][r] = val; end
      2: if (n > I && n <= N && r <= R) begin ok = 1'b1; sh_rows[n-I] = r; end
      4: begin
        ok = 1'b1;
        for (int k = 1; k <= NC; k++) begin
          sh_rows[k] = 0;
          for (int j = 0; j < R; j++) sh_tab[k][j] = 0;
        end
      end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [39:0] p);
    for (int i = 0; i < pkt_len(p[7:0]); i++) send_byte(p[8*i +: 8]);
  endtask

  task automatic send_packet(input logic [39:0] p, input string name);
    bit ok;
    send_raw(p);
    model_packet(p, ok);
    if (ok) exp_done++;
    else exp_err++;
    check({name, "_done_cnt"}, done_cnt, exp_done);
    check({name, "_err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic compare_active(input string name);
    for (int k = 1; k <= NC; k++) begin
      check($sformatf("%s_rows_n%0d", name, k + I), cfg_num_rows[k], act_rows[k]);
      for (int r = 0; r < R; r++)
        check($sformatf("%s_n%0d_r%0d", name, k + I, r), cfg_table_contents[k][r], act_tab[k][r]);
    end
  endtask

  // hold = cycles net_idle stays low after the COMMIT byte is accepted.
  task automatic do_commit(input int hold, input string name);
    logic [NC:1][R-1:0][E-1:0] prev_tab;
    logic [NC:1][RCW-1:0] prev_rows;
    bit stable_bad;
    int guard;
    prev_tab = cfg_table_contents;
    prev_rows = cfg_num_rows;
    stable_bad = 1'b0;
    net_idle = (hold == 0);
    send_byte(OP_COMMIT);
    check({name, "_ready_low"}, in_ready, 0);
    check({name, "_no_early_copy"}, (cfg_table_contents === prev_tab) && (cfg_num_rows === prev_rows), 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (in_ready !== 1'b0 || cfg_table_contents !== prev_tab || cfg_num_rows !== prev_rows)
        stable_bad = 1'b1;
    end
    if (hold > 0) check({name, "_held_stable"}, stable_bad, 0);
    net_idle = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_wait_bounded"}, guard < 100, 1);
    check({name, "_update_pulse"}, cfg_update, 1);
    for (int k = 1; k <= NC; k++) begin
      act_rows[k] = sh_rows[k];
      for (int r = 0; r < R; r++) act_tab[k][r] = sh_tab[k][r];
    end
    exp_done++;
    exp_upd++;
    check({name, "_done_cnt"}, done_cnt, exp_done);
    check({name, "_upd_cnt"}, upd_cnt, exp_upd);
    compare_active(name);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    model_zero();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [39:0] p;
    int d0, e0, x;

    vecs[0]  = '{pkt: 40'h3FFF000A01, exp_ok: 1'b1};
    vecs[1]  = '{pkt: 40'h1234031501, exp_ok: 1'b1};
    vecs[2]  = '{pkt: 40'h1111000901, exp_ok: 1'b0};
    vecs[3]  = '{pkt: 40'h2222001601, exp_ok: 1'b0};
    vecs[4]  = '{pkt: 40'h3333040C01, exp_ok: 1'b0};
    vecs[5]  = '{pkt: 40'h0000050A02, exp_ok: 1'b0};
    vecs[6]  = '{pkt: 40'h0000040A02, exp_ok: 1'b1};
    vecs[7]  = '{pkt: 40'h0000001502, exp_ok: 1'b1};
    vecs[8]  = '{pkt: 40'h0000000000, exp_ok: 1'b0};
    vecs[9]  = '{pkt: 40'h0000000005, exp_ok: 1'b0};
    vecs[10] = '{pkt: 40'h2211090001, exp_ok: 1'b0};
    vecs[11] = '{pkt: 40'hFFFF010B01, exp_ok: 1'b1};

    model_zero();
    tick();
    tick();
    check("reset_in_ready_hi", in_ready, 1);
    rst = 1'b0;
    tick();
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_update", cfg_update, 0);
    check("reset_table_zero", cfg_table_contents == '0, 1);
    check("reset_rows_zero", cfg_num_rows == '0, 1);

    // Worked example: N18 row0 = {16,24}, four rows, commit.
    send_packet(40'h2018001201, "ex_write");
    send_packet(40'h0000041202, "ex_rows");
    do_commit(0, "ex_commit");
    check("ex_entry_n18_r0", cfg_table_contents[18-I][0], 16'h2018);
    check("ex_rows_n18", cfg_num_rows[18-I], 4);
    check("ex_done_total", done_cnt, 3);
    check("ex_upd_total", upd_cnt, 1);

    // Directed vectors, back-to-back.
    for (int v = 0; v < 12; v++) begin
      bit ok;
      d0 = done_cnt;
      e0 = err_cnt;
      send_raw(vecs[v].pkt);
      model_packet(vecs[v].pkt, ok);
      if (vecs[v].exp_ok) exp_done++;
      else exp_err++;
      check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_ok ? 1 : 0);
      check($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].exp_ok ? 0 : 1);
    end
    do_commit(0, "vec_commit");

    // Invalid writes leave shadow alone; the next valid packet parses.
    send_packet(40'h0ABC000901, "bad_n9");
    send_packet(40'h0ABC001601, "bad_n22");
    send_packet(40'h0ABC040D01, "bad_row4");
    send_packet(40'h01C3020D01, "good_after_bad");
    do_commit(0, "bad_commit");

    // Network busy for 50 cycles; net_idle drops with the COMMIT byte.
    send_packet(40'h0777011001, "busy_write");
    do_commit(50, "busy_commit");

    // Shadow write without commit, then CLEAR + COMMIT.
    send_packet(40'h1555021101, "nocommit_write");
    send_packet(40'h0000021102, "nocommit_rows");
    tick();
    compare_active("nocommit");
    send_packet(40'h0000000004, "clear");
    do_commit(0, "clear_commit");
    check("clear_table_zero", cfg_table_contents == '0, 1);

    // Reset after two bytes of a WRITE_ROW.
    send_packet(40'h0321001401, "pre_rst_write");
    do_commit(0, "pre_rst_commit");
    send_byte(8'h01);
    send_byte(8'h0C);
    apply_reset();
    check("rst_mid_done_cnt", done_cnt, exp_done);
    check("rst_mid_err_cnt", err_cnt, exp_err);
    check("rst_mid_table_zero", cfg_table_contents == '0, 1);
    send_packet(40'h0055020C01, "post_rst_write");
    do_commit(0, "post_rst_commit");

    // Reset while waiting for the network.
    net_idle = 1'b0;
    send_byte(OP_COMMIT);
    tick();
    tick();
    apply_reset();
    net_idle = 1'b1;
    tick();
    tick();
    check("rst_wait_upd_cnt", upd_cnt, exp_upd);
    check("rst_wait_done_cnt", done_cnt, exp_done);
    check("rst_wait_ready", in_ready, 1);
    compare_active("rst_wait");

    // Unknown opcode followed immediately by SET_ROWS.
    d0 = done_cnt;
    e0 = err_cnt;
    send_packet(40'h000000007F, "unk_7f");
    send_packet(40'h0000031302, "unk_then_rows");
    check("unk_err_once", err_cnt - e0, 1);
    check("unk_done_once", done_cnt - d0, 1);
    do_commit(0, "unk_commit");

    // Randomized packets against the model.
    for (int it = 0; it < 150; it++) begin
      x = $urandom_range(0, 99);
      if (x < 8) begin
        do_commit($urandom_range(0, 4), $sformatf("rnd%0d_commit", it));
      end else begin
        p[39:24] = 16'($urandom());
        p[15:8]  = 8'($urandom_range(8, 23));
        if (x < 50) begin
          p[7:0] = 8'h01;
          p[23:16] = 8'($urandom_range(0, 4));
        end else if (x < 80) begin
          p[7:0] = 8'h02;
          p[23:16] = 8'($urandom_range(0, 5));
        end else if (x < 85) begin
          p[7:0] = 8'h04;
          p[23:16] = 8'h00;
        end else begin
          p[7:0] = 8'($urandom_range(0, 255));
          if (p[7:0] >= 8'h01 && p[7:0] <= 8'h04) p[7:0] = 8'hA5;
          p[23:16] = 8'h00;
        end
        send_packet(p, $sformatf("rnd%0d", it));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    do_commit(1, "rnd_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
